// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: register index, opcode encoding and the opcodes
// the hazard logic needs to recognise.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;
    typedef logic [5:0] opcode_t;

    localparam opcode_t RTYPE = 6'b000000;
    localparam opcode_t LW    = 6'b100011;
    localparam opcode_t SW    = 6'b101011;

endpackage

// File: rtl/pipeline_hazard_tracker_pkg.sv
// Pipeline movement types: the hazard FSM states and the per-stage shadow
// record of destination register, write enable and opcode.
package pipeline_hazard_tracker_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } hazard_state_t;

    typedef struct packed {
        regbits_t dest;
        logic     wen;
        opcode_t  op;
    } stage_shadow_t;

    localparam stage_shadow_t BUBBLE = '{dest: 5'd0, wen: 1'b0, op: RTYPE};

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline register: loads on enable, loads a bubble instead when
// flushed, otherwise holds.
module hazard_shadow_stage
    import pipeline_hazard_tracker_pkg::*;
(
    input  logic          clk,
    input  logic          n_rst,
    input  logic          en,
    input  logic          flush,
    input  stage_shadow_t d,
    output stage_shadow_t q
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= flush ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_tracker.sv
// EX-stage forwarding producer: shadows dest/WEN/opcode through ID/EX, EX/MEM
// and MEM/WB, and sequences advance, load-use stall, flush and memory waits.
module pipeline_hazard_tracker
    import cpu_types_pkg::*;
    import pipeline_hazard_tracker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic [4:0]       wsel_ID,
    input  logic             WEN_ID,
    input  logic [5:0]       opcode_ID,
    input  logic             branch_taken_EX,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             dmem_req,
    output logic [4:0]       reg_wr_mem,
    output logic             WEN_EX_MEM,
    output logic [5:0]       opcode_EX_MEM,
    output logic [4:0]       reg_wr_wb,
    output logic             WEN_MEM_WB,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    hazard_state_t state, next_state;
    stage_shadow_t idex_q, exmem_q, memwb_q, id_d;
    logic          advance, memop, load_use;
    logic          memwb_op_unused;

    assign id_d = '{dest: wsel_ID, wen: WEN_ID, op: opcode_ID};

    assign memop    = (exmem_q.op == LW) || (exmem_q.op == SW);
    assign load_use = (idex_q.op == LW) && (idex_q.dest != 5'd0) &&
                      ((idex_q.dest == rs_ID) || (uses_rt_ID && (idex_q.dest == rt_ID)));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // A memory op sitting in EX/MEM freezes the pipe until the shared port
    // has served the data access and the fetch has also completed.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            RUN: begin
                if (memop) begin
                    next_state = DWAIT;
                end else begin
                    advance = ihit;
                end
            end
            DWAIT: begin
                dmem_req = 1'b1;
                if (dhit && ihit) begin
                    advance    = 1'b1;
                    next_state = RUN;
                end else if (dhit) begin
                    next_state = IWAIT;
                end
            end
            IWAIT: begin
                if (ihit) begin
                    advance    = 1'b1;
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // A taken branch flushes the dependent instruction, so it overrides the stall.
    assign pc_en      = advance && (branch_taken_EX || !load_use);
    assign ifid_en    = advance && !load_use;
    assign ifid_flush = advance && branch_taken_EX;
    assign idex_flush = advance && (branch_taken_EX || load_use);

    hazard_shadow_stage u_idex (
        .clk   (CLK),
        .n_rst (nRST),
        .en    (advance),
        .flush (idex_flush),
        .d     (id_d),
        .q     (idex_q)
    );

    hazard_shadow_stage u_exmem (
        .clk   (CLK),
        .n_rst (nRST),
        .en    (advance),
        .flush (1'b0),
        .d     (idex_q),
        .q     (exmem_q)
    );

    hazard_shadow_stage u_memwb (
        .clk   (CLK),
        .n_rst (nRST),
        .en    (advance),
        .flush (1'b0),
        .d     (exmem_q),
        .q     (memwb_q)
    );

    assign reg_wr_mem    = exmem_q.dest;
    assign WEN_EX_MEM    = exmem_q.wen;
    assign opcode_EX_MEM = exmem_q.op;
    assign reg_wr_wb     = memwb_q.dest;
    assign WEN_MEM_WB    = memwb_q.wen;

    // The write-back opcode is shadowed for symmetry but has no consumer here.
    assign memwb_op_unused = ^memwb_q.op;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            lu_stall_cnt <= '0;
        end else if (advance && load_use && !branch_taken_EX && !(&lu_stall_cnt)) begin
            lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Scoreboard bench for pipeline_hazard_tracker: directed sequences then random
// traffic, each cycle checked against a queue-based pipeline model.
module tb_pipeline_hazard_tracker;
    import cpu_types_pkg::*;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST, ihit, dhit, uses_rt_ID, WEN_ID, branch_taken_EX;
    logic [4:0]       rs_ID, rt_ID, wsel_ID;
    logic [5:0]       opcode_ID;
    logic             pc_en, ifid_en, ifid_flush, idex_flush, dmem_req;
    logic [4:0]       reg_wr_mem, reg_wr_wb;
    logic             WEN_EX_MEM, WEN_MEM_WB;
    logic [5:0]       opcode_EX_MEM;
    logic [CNT_W-1:0] lu_stall_cnt;

    typedef struct {
        int dest;
        int wen;
        int op;
    } slot_t;

    typedef struct {
        int pc_en, ifid_en, ifid_flush, idex_flush, dmem_req;
        int reg_wr_mem, wen_exmem, op_exmem, reg_wr_wb, wen_memwb, cnt;
    } expect_t;

    expect_t exp_q[$];
    slot_t   pipe[3];
    int      mem_phase;
    int      stall_total;
    bit      model_valid = 1'b0;
    int      checks = 0;
    int      errors = 0;

    pipeline_hazard_tracker #(.CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ihit            (ihit),
        .dhit            (dhit),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .uses_rt_ID      (uses_rt_ID),
        .wsel_ID         (wsel_ID),
        .WEN_ID          (WEN_ID),
        .opcode_ID       (opcode_ID),
        .branch_taken_EX (branch_taken_EX),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .dmem_req        (dmem_req),
        .reg_wr_mem      (reg_wr_mem),
        .WEN_EX_MEM      (WEN_EX_MEM),
        .opcode_EX_MEM   (opcode_EX_MEM),
        .reg_wr_wb       (reg_wr_wb),
        .WEN_MEM_WB      (WEN_MEM_WB),
        .lu_stall_cnt    (lu_stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
        end
    endtask

    // Drives one cycle of inputs, records what the outputs must be during that
    // cycle, then moves the model across the coming clock edge.
    task automatic apply_stimulus(input bit rst_n, input bit ih, input bit dh,
                                  input int rs, input int rt, input bit urt,
                                  input int wsel, input bit wen, input int op, input bit br);
        expect_t e;
        bit      is_mem, lu, adv;
        @(negedge CLK);
        nRST = rst_n; ihit = ih; dhit = dh;
        rs_ID = 5'(rs); rt_ID = 5'(rt); uses_rt_ID = urt;
        wsel_ID = 5'(wsel); WEN_ID = wen; opcode_ID = 6'(op); branch_taken_EX = br;
        #1;
        is_mem = (pipe[1].op == int'(LW)) || (pipe[1].op == int'(SW));
        lu = (pipe[0].op == int'(LW)) && (pipe[0].dest != 0) &&
             ((pipe[0].dest == rs) || (urt && (pipe[0].dest == rt)));
        if (mem_phase == 2)      adv = ih;
        else if (mem_phase == 1) adv = dh && ih;
        else                     adv = ih && !is_mem;
        if (model_valid) begin
            e.pc_en      = int'(adv && (br || !lu));
            e.ifid_en    = int'(adv && !lu);
            e.ifid_flush = int'(adv && br);
            e.idex_flush = int'(adv && (br || lu));
            e.dmem_req   = int'(mem_phase == 1);
            e.reg_wr_mem = pipe[1].dest;
            e.wen_exmem  = pipe[1].wen;
            e.op_exmem   = pipe[1].op;
            e.reg_wr_wb  = pipe[2].dest;
            e.wen_memwb  = pipe[2].wen;
            e.cnt        = (stall_total > CNT_MAX) ? CNT_MAX : stall_total;
            exp_q.push_back(e);
        end
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{dest: 0, wen: 0, op: 0};
            mem_phase   = 0;
            stall_total = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            case (mem_phase)
                0: if (is_mem) mem_phase = 1;
                1: if (dh && ih) mem_phase = 0; else if (dh) mem_phase = 2;
                default: if (ih) mem_phase = 0;
            endcase
            if (adv) begin
                if (lu && !br) stall_total++;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (br || lu) pipe[0] = '{dest: 0, wen: 0, op: 0};
                else          pipe[0] = '{dest: wsel, wen: int'(wen), op: op};
            end
        end
    endtask

    task automatic nop(input bit ih, input bit dh);
        apply_stimulus(1'b1, ih, dh, 0, 0, 1'b0, 0, 1'b0, int'(RTYPE), 1'b0);
    endtask

    // Monitor: every cycle with a recorded expectation, compare mid-cycle.
    initial begin
        expect_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("pc_en",         int'(pc_en),         e.pc_en);
                check_output("ifid_en",       int'(ifid_en),       e.ifid_en);
                check_output("ifid_flush",    int'(ifid_flush),    e.ifid_flush);
                check_output("idex_flush",    int'(idex_flush),    e.idex_flush);
                check_output("dmem_req",      int'(dmem_req),      e.dmem_req);
                check_output("reg_wr_mem",    int'(reg_wr_mem),    e.reg_wr_mem);
                check_output("WEN_EX_MEM",    int'(WEN_EX_MEM),    e.wen_exmem);
                check_output("opcode_EX_MEM", int'(opcode_EX_MEM), e.op_exmem);
                check_output("reg_wr_wb",     int'(reg_wr_wb),     e.reg_wr_wb);
                check_output("WEN_MEM_WB",    int'(WEN_MEM_WB),    e.wen_memwb);
                check_output("lu_stall_cnt",  int'(lu_stall_cnt),  e.cnt);
            end
        end
    end

    initial begin
        int r, op, br_n;
        for (int i = 0; i < 3; i++) pipe[i] = '{dest: 0, wen: 0, op: 0};
        mem_phase = 0; stall_total = 0;
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; uses_rt_ID = 1'b0; WEN_ID = 1'b0;
        branch_taken_EX = 1'b0; rs_ID = '0; rt_ID = '0; wsel_ID = '0; opcode_ID = '0;

        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);

        // Back-to-back R-types writing $5 and $6.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1, 2, 1'b1, 5, 1'b1, int'(RTYPE), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1, 2, 1'b1, 6, 1'b1, int'(RTYPE), 1'b0);
        repeat (3) nop(1'b1, 1'b0);

        // LW $4 followed by a dependent ADD, then the load's memory wait.
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 4, 1'b1, int'(LW), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4, 3, 1'b1, 7, 1'b1, int'(RTYPE), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4, 3, 1'b1, 7, 1'b1, int'(RTYPE), 1'b0);
        repeat (3) nop(1'b1, 1'b0);
        nop(1'b0, 1'b1);
        nop(1'b1, 1'b0);
        repeat (3) nop(1'b1, 1'b0);

        // Branch taken while a load-use hazard is present.
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 9, 1'b1, int'(LW), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 9, 1'b1, 3, 1'b1, int'(RTYPE), 1'b1);
        repeat (4) nop(1'b1, 1'b1);

        // Five load-use stalls push the narrow counter into saturation.
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 4, 1'b1, int'(LW), 1'b0);
            apply_stimulus(1'b1, 1'b1, 1'b1, 4, 0, 1'b0, 2, 1'b1, int'(RTYPE), 1'b0);
            repeat (4) nop(1'b1, 1'b1);
        end

        // Reset while a store is waiting on the data port.
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, int'(SW), 1'b0);
        repeat (3) nop(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, int'(RTYPE), 1'b0);
        repeat (2) nop(1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = int'(LW);
            else if (r < 5) op = int'(SW);
            else if (r < 8) op = int'(RTYPE);
            else            op = 8;
            br_n = ($urandom_range(0, 6) == 0) ? 1 : 0;
            apply_stimulus(($urandom_range(0, 99) != 0),
                           ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 2) == 0),
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           op, 1'(br_n));
        end

        @(negedge CLK);
        #3;
        check_output("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
